b2s_tx_scheduler: RTL

B2S_TX_SCHEDULER -- requirements
Module: b2s_tx_scheduler

---
 rtl/b2s_pkg.sv | 22 ++
 rtl/b2s_tx_scheduler_if.sv | 27 ++
 rtl/b2s_rr_arbiter.sv | 33 +++
 rtl/b2s_tx_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/b2s_pkg.sv
// Shared definitions for the pulse-width serial link: FSM states and the default
// timing constants that the receiver's decode windows are built from.
package b2s_pkg;

  localparam int unsigned DUR_W          = 8;
  localparam int unsigned DEF_WIDTH      = 64;
  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_START_LOW  = 240;
  localparam int unsigned DEF_ONE_LOW    = 16;
  localparam int unsigned DEF_ZERO_LOW   = 96;
  localparam int unsigned DEF_HIGH_T     = 16;
  localparam int unsigned DEF_GAP_T      = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LO,
    S_BIT_HI,
    S_BIT_LO,
    S_GAP
  } state_e;

endpackage

// File: rtl/b2s_tx_scheduler_if.sv
// Requester bus plus serial-line status of the transmit scheduler.
interface b2s_tx_scheduler_if import b2s_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ
) ();

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic                  b2s_dout;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  frame_done;

  modport master (
    output req_valid, req_data,
    input  req_ack, b2s_dout, busy, grant_id, frame_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ack, b2s_dout, busy, grant_id, frame_done
  );

endinterface

// File: rtl/b2s_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module b2s_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt_oh_c,
  output logic [$clog2(NREQ)-1:0] gnt_idx_c,
  output logic                    gnt_any_c
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = IDW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    cand      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = CW'(ptr) + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!gnt_any_c && req[cand[IDW-1:0]]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = cand[IDW-1:0];
      end
    end
    if (gnt_any_c) gnt_oh_c[gnt_idx_c] = 1'b1;
  end

endmodule

// File: rtl/b2s_tx_scheduler.sv
// Arbitrates NREQ frame requesters and serialises the winner's payload LSB first
// as start pulse, per-bit high/low pulses (low width encodes the bit) and a gap.
module b2s_tx_scheduler import b2s_pkg::*; #(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned START_LOW = DEF_START_LOW,
  parameter int unsigned ONE_LOW   = DEF_ONE_LOW,
  parameter int unsigned ZERO_LOW  = DEF_ZERO_LOW,
  parameter int unsigned HIGH_T    = DEF_HIGH_T,
  parameter int unsigned GAP_T     = DEF_GAP_T
) (
  input  logic                clk,
  input  logic                rst,
  b2s_tx_scheduler_if.slave   bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned BCW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [BCW-1:0]     bit_q, bit_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NREQ-1:0]    win_oh;
  logic [IDW-1:0]     win_idx;
  logic               win_any;

  b2s_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .gnt_oh_c  (win_oh),
    .gnt_idx_c (win_idx),
    .gnt_any_c (win_any)
  );

  // Every duration counter loads (length-1) on state entry and leaves at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_START_LO;
          cnt_d   = DUR_W'(START_LOW - 1);
          bit_d   = '0;
          shreg_d = bus.req_data[win_idx*WIDTH +: WIDTH];
          grant_d = win_idx;
          ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          ack_d   = win_oh;
        end
      end
      S_START_LO: begin
        if (cnt_q == '0) begin
          state_d = S_BIT_HI;
          cnt_d   = DUR_W'(HIGH_T - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BIT_HI: begin
        if (cnt_q == '0) begin
          state_d = S_BIT_LO;
          cnt_d   = shreg_q[0] ? DUR_W'(ONE_LOW - 1) : DUR_W'(ZERO_LOW - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BIT_LO: begin
        if (cnt_q == '0) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_d == BCW'(WIDTH)) begin
            state_d = S_GAP;
            cnt_d   = DUR_W'(GAP_T - 1);
          end else begin
            state_d = S_BIT_HI;
            cnt_d   = DUR_W'(HIGH_T - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line and busy are registered from the next state so they align with state_q.
    dout_d = !((state_d == S_START_LO) || (state_d == S_BIT_LO));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.b2s_dout   = dout_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.frame_done = done_q;

endmodule
